// File: rtl/tecmo_pkg.sv
// Shared types for the ROM download writer.
//   wr_state_t  - request FSM states
//   rom_word_t  - one packed SDRAM write: word address plus 32-bit data
// ROM_ADDR_WIDTH is the widest SDRAM word address the writer carries
// internally; narrower ADDR_WIDTH settings truncate on output.
package tecmo_pkg;

  localparam int ROM_ADDR_WIDTH = 23;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [ROM_ADDR_WIDTH-1:0] addr;
    logic [31:0]               data;
  } rom_word_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of rom_word_t entries.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   push, push_word      - write request and entry
//   pop                  - read request; pop_word shows the head entry
//   full, empty          - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo
  import tecmo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  rom_word_t push_word,
  input  logic      pop,
  output rom_word_t pop_word,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  rom_word_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_word = mem[rd_ptr];

endmodule

// File: rtl/sdram_rom_writer.sv
// Packs HPS ioctl download bytes into 32-bit words, queues them and writes
// them to the SDRAM controller over its req/ack port.
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   ioctl_addr/data/wr/download        - HPS download byte stream
//   sdram_addr/data/we/req, sdram_ack  - SDRAM controller write request port
//   busy      - download active, data queued, or request outstanding
//   done      - one-cycle pulse once a finished download has fully drained
//   overflow  - sticky; a completed word was dropped on a full FIFO
//   checksum  - 16-bit sum of accepted bytes
// Build option: define ROM_WRITER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
//
// state | meaning
// IDLE  | no request; pops the FIFO head into the output word when available
// REQ   | sdram_req/sdram_we high, address/data held until sdram_ack
module sdram_rom_writer
  import tecmo_pkg::*;
#(
  parameter int          ADDR_WIDTH = 23,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [19:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  input  logic                  ioctl_download,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [31:0]           sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           checksum
);

  logic        dl_q;
  logic        start;
  logic        fall;
  logic        accept;

  // Packer: pk_full marks a complete word that could not be pushed in the
  // cycle it completed (a partial word was pushed in that same cycle).
  logic        pk_valid;
  logic        pk_full;
  logic [17:0] pk_waddr;
  logic [31:0] pk_data;

  logic        nxt_valid;
  logic        nxt_full;
  logic [17:0] nxt_waddr;
  logic [31:0] nxt_data;

  logic        push;
  logic [17:0] push_waddr;
  logic [31:0] push_data;
  rom_word_t   push_word;

  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  rom_word_t   head_word;
  rom_word_t   out_word;

  wr_state_t   state_q;
  wr_state_t   state_d;

  logic        done_pend;

  assign start  = ioctl_download & ~dl_q;
  assign fall   = dl_q & ~ioctl_download;
  assign accept = ioctl_wr & ioctl_download;

  // Word completion and packer update. The completed word goes straight
  // into the FIFO so it is visible there the cycle after the byte strobe.
  always_comb begin
    nxt_valid  = pk_valid & ~start;
    nxt_full   = pk_full & ~start;
    nxt_waddr  = pk_waddr;
    nxt_data   = start ? 32'h0 : pk_data;
    push       = 1'b0;
    push_waddr = nxt_waddr;
    push_data  = nxt_data;

    if (nxt_full) begin
      push      = 1'b1;
      nxt_valid = 1'b0;
      nxt_full  = 1'b0;
      nxt_data  = 32'h0;
    end else if (accept && nxt_valid && (ioctl_addr[19:2] != nxt_waddr)) begin
      push      = 1'b1;
      nxt_valid = 1'b0;
      nxt_data  = 32'h0;
    end else if (fall && nxt_valid) begin
      push      = 1'b1;
      nxt_valid = 1'b0;
      nxt_data  = 32'h0;
    end

    if (accept) begin
      nxt_data[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;
      nxt_waddr = ioctl_addr[19:2];
      if (ioctl_addr[1:0] == 2'd3) begin
        if (push) begin
          nxt_valid = 1'b1;
          nxt_full  = 1'b1;
        end else begin
          push       = 1'b1;
          push_waddr = ioctl_addr[19:2];
          push_data  = nxt_data;
          nxt_valid  = 1'b0;
          nxt_data   = 32'h0;
        end
      end else begin
        nxt_valid = 1'b1;
      end
    end
  end

  assign push_word.addr = ROM_ADDR_WIDTH'(BASE_ADDR + 32'(push_waddr));
  assign push_word.data = push_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      pk_valid <= 1'b0;
      pk_full  <= 1'b0;
      pk_waddr <= '0;
      pk_data  <= '0;
      overflow <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      pk_valid <= nxt_valid;
      pk_full  <= nxt_full;
      pk_waddr <= nxt_waddr;
      pk_data  <= nxt_data;
      if (start)
        overflow <= 1'b0;
      else if (push && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .pop_word  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  out_word <= '0;
    else if (pop)  out_word <= head_word;
  end

  assign sdram_req  = (state_q == REQ);
  assign sdram_we   = sdram_req;
  assign sdram_addr = ADDR_WIDTH'(out_word.addr);
  assign sdram_data = out_word.data;

  // done_pend arms on the download falling edge and is consumed by the
  // single done pulse, so done cannot repeat until the next download ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   done_pend <= 1'b0;
    else if (start) done_pend <= 1'b0;
    else if (fall)  done_pend <= 1'b1;
    else if (done)  done_pend <= 1'b0;
  end

  assign done = done_pend & ~ioctl_download & ~pk_valid & fifo_empty & (state_q == IDLE);
  assign busy = dl_q | pk_valid | ~fifo_empty | (state_q == REQ);

`ifdef ROM_WRITER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sum_q <= '0;
    else if (start)
      sum_q <= accept ? {8'h00, ioctl_data} : 16'h0000;
    else if (accept)
      sum_q <= sum_q + {8'h00, ioctl_data};
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_rom_writer.sv
`timescale 1ns/1ps
module tb_sdram_rom_writer;

  localparam int          AW   = 23;
  localparam int unsigned BASE = 32'h100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [19:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic          ioctl_wr = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [AW-1:0] sdram_addr;
  logic [31:0]   sdram_data;
  logic          sdram_we;
  logic          sdram_req;
  logic          sdram_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [15:0]   checksum;

  always #5 clk = ~clk;

  sdram_rom_writer #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_wr      (ioctl_wr),
    .ioctl_download(ioctl_download),
    .sdram_addr    (sdram_addr),
    .sdram_data    (sdram_data),
    .sdram_we      (sdram_we),
    .sdram_req     (sdram_req),
    .sdram_ack     (sdram_ack),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .checksum      (checksum)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   acks = 0;
  int   dones = 0;
  int   exp_dones = 0;
  bit   ack_hold = 1'b0;
  int   lat_min = 0;
  int   lat_max = 2;
  int   ack_wait = 0;

  // Reference model: bytes grouped into words by word address.
  bit          m_valid = 1'b0;
  logic [17:0] m_waddr = '0;
  logic [31:0] m_data = '0;
  logic [15:0] m_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_emit();
    exp_t e;
    e.addr = AW'(BASE + 32'(m_waddr));
    e.data = m_data;
    exp_q.push_back(e);
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic m_byte(input logic [19:0] a, input logic [7:0] d);
    int lane;
    lane = int'(a[1:0]);
    if (m_valid && a[19:2] != m_waddr) m_emit();
    if (!m_valid) begin
      m_valid = 1'b1;
      m_waddr = a[19:2];
      m_data  = '0;
    end
    m_data[lane*8 +: 8] = d;
    m_sum = m_sum + 16'(d);
    if (lane == 3) m_emit();
  endtask

  function automatic logic [15:0] exp_sum();
`ifdef ROM_WRITER_CHECKSUM_EN
    return m_sum;
`else
    return 16'h0000;
`endif
  endfunction

  // Ack responder and scoreboard monitor: a request is accepted on the edge
  // following a negedge where both req and ack are high.
  initial begin
    forever begin
      @(negedge clk);
      sdram_ack = 1'b0;
      if (done) dones++;
      if (reset_n && sdram_req && !ack_hold) begin
        if (ack_wait <= 0) begin
          sdram_ack = 1'b1;
          acks++;
          chk("we_with_req", 64'(sdram_we), 64'd1);
          chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("req_addr", 64'(sdram_addr), 64'(e.addr));
            chk("req_data", 64'(sdram_data), 64'(e.data));
          end
          ack_wait = $urandom_range(lat_max, lat_min);
        end else begin
          ack_wait--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    m_valid = 1'b0;
    m_data  = '0;
    m_sum   = '0;
    ioctl_download = 1'b1;
    step(1);
  endtask

  task automatic wr_byte(input logic [19:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    m_byte(a, d);
    step(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (m_valid) m_emit();
    exp_dones++;
    step(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      step(1);
    end
    chk(name, 64'(exp_q.size() == 0 && !busy), 64'd1);
    step(3);
  endtask

  initial begin
    int          a0;
    int          n;
    int          r;
    logic [19:0] cur;

    reset_n = 1'b0;
    step(3);
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    step(2);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_data", 64'(sdram_data), 64'd0);

    // Single full word, ack after 3 cycles, with request latency check.
    lat_min = 3; lat_max = 3; ack_wait = 3;
    a0 = acks;
    start_dl();
    wr_byte(20'h0, 8'h11);
    wr_byte(20'h1, 8'h22);
    wr_byte(20'h2, 8'h33);
    wr_byte(20'h3, 8'h44);
    chk("t1_req_n1", 64'(sdram_req), 64'd0);
    step(1);
    chk("t1_req_n2", 64'(sdram_req), 64'd1);
    end_dl();
    wait_drain("t1_drain", 50);
    chk("t1_acks", 64'(acks - a0), 64'd1);
    chk("t1_done", 64'(dones), 64'(exp_dones));
    chk("t1_checksum", 64'(checksum), 64'(exp_sum()));

    // Six bytes, partial word flushed when the download ends.
    lat_min = 0; lat_max = 2; ack_wait = 0;
    a0 = acks;
    start_dl();
    for (int i = 0; i < 6; i++) wr_byte(20'(i), 8'(8'h11 * (i + 1)));
    end_dl();
    wait_drain("t2_drain", 50);
    chk("t2_acks", 64'(acks - a0), 64'd2);
    chk("t2_done", 64'(dones), 64'(exp_dones));

    // Two isolated bytes in different words.
    a0 = acks;
    start_dl();
    wr_byte(20'h10, 8'haa);
    step(2);
    wr_byte(20'h20, 8'hbb);
    end_dl();
    wait_drain("t4_drain", 50);
    chk("t4_acks", 64'(acks - a0), 64'd2);
    chk("t4_done", 64'(dones), 64'(exp_dones));

    // Stalled controller: 32 bytes stream while ack is held off.
    ack_hold = 1'b1;
    a0 = acks;
    start_dl();
    for (int i = 0; i < 32; i++) wr_byte(20'(i), 8'(i + 1));
    step(200 - 33);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_held_req", 64'(sdram_req), 64'd1);
    chk("t3_no_acks", 64'(acks - a0), 64'd0);
    end_dl();
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    ack_hold = 1'b0;
    wait_drain("t3_drain", 100);
    chk("t3_acks", 64'(acks - a0), 64'd5);
    chk("t3_done", 64'(dones), 64'(exp_dones));
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);

    // 258 bytes of 0xFF, immediate ack; overflow clears at start.
    lat_min = 0; lat_max = 0; ack_wait = 0;
    start_dl();
    chk("t6_overflow_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 258; i++) wr_byte(20'(i), 8'hff);
    end_dl();
    wait_drain("t6_drain", 200);
    chk("t6_checksum", 64'(checksum), 64'(exp_sum()));
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_done", 64'(dones), 64'(exp_dones));

    // Randomized downloads.
    lat_min = 0; lat_max = 2;
    for (int dl = 0; dl < 4; dl++) begin
      start_dl();
      n   = $urandom_range(40, 20);
      cur = 20'($urandom_range(20'hfffff, 0));
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(3, 0);
        if (r == 0)      cur = 20'($urandom_range(20'hfffff, 0));
        else if (r == 1) cur = {cur[19:2], 2'($urandom_range(3, 0))};
        else             cur = cur + 20'd1;
        wr_byte(cur, 8'($urandom_range(255, 0)));
        step($urandom_range(6, 3));
      end
      end_dl();
      wait_drain("rnd_drain", 300);
      chk("rnd_done", 64'(dones), 64'(exp_dones));
      chk("rnd_overflow", 64'(overflow), 64'd0);
      chk("rnd_checksum", 64'(checksum), 64'(exp_sum()));
    end

    // Reset while a request is outstanding.
    ack_hold = 1'b1;
    start_dl();
    for (int i = 0; i < 32; i++) wr_byte(20'(i), 8'(i));
    chk("t5_pre_req", 64'(sdram_req), 64'd1);
    chk("t5_pre_overflow", 64'(overflow), 64'd1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("t5_req", 64'(sdram_req), 64'd0);
    chk("t5_we", 64'(sdram_we), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_valid = 1'b0;
    a0 = acks;
    n = dones;
    ack_hold = 1'b0;
    step(30);
    chk("t5_no_req", 64'(acks - a0), 64'd0);
    chk("t5_req_low", 64'(sdram_req), 64'd0);
    chk("t5_no_done", 64'(dones - n), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
